// File: rtl/keypad_scan_ctrl_pkg.sv
// ============================================================================
// keypad_scan_ctrl_pkg
// Shared definitions for the 4x4 matrix keypad scanner.
// The MMIO read path also uses these definitions.
//   KEY_NONE       : key code reported when no key has been accepted yet
//   scan_state_t   : scan sequencer states (SCAN / DEBOUNCE / PRESSED)
//   onehot_to_idx  : 4-bit one-hot to 2-bit index encoder
//   is_onehot      : true when exactly one bit of a 4-bit vector is set
// ============================================================================
package keypad_scan_ctrl_pkg;

    localparam logic [4:0] KEY_NONE = 5'h10;

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2
    } scan_state_t;

    // Input that is not one-hot maps to index 0.
    // Callers qualify the result with is_onehot first.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        case (oh)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_scan_tick_gen.sv
// ============================================================================
// scan_tick_gen
// Row-dwell timer. Pulses tick on the last cycle of every DIV-cycle dwell.
//   clk   in  system clock
//   reset in  synchronous active-high reset; the dwell restarts from zero
//   tick  out one-cycle pulse, every DIV cycles
// ============================================================================
module scan_tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // The counter counts 0..DIV-1 and then starts again at 0.
    // It never runs past LAST, so it never wraps on its own.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// ============================================================================
// keypad_scan_ctrl
// Scan sequencer for the 4x4 matrix keypad. It drives one-hot row strobes and
// samples the column returns. It debounces presses and releases, and it
// delivers one key code per press together with a one-cycle valid strobe.
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   col[3:0]   in   column returns, active-high, asynchronous to clk
//   row[3:0]   out  one-hot active-high row strobe
//   key[4:0]   out  {0,row_idx,col_idx}; 5'h10 = no key accepted yet
//   key_valid  out  one-cycle pulse when a debounced press is accepted
//   key_held   out  high while the accepted key remains pressed
// ============================================================================
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [4:0] key,
    output logic       key_valid,
    output logic       key_held
);

    import keypad_scan_ctrl_pkg::*;

    localparam int MW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_CNT - 1);

    logic [3:0]    col_meta;
    logic [3:0]    col_s;
    logic          tick;
    scan_state_t   state;
    logic [3:0]    cand;
    logic [MW-1:0] match_cnt;
    logic [MW-1:0] rel_cnt;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;
    logic          col_ok;
    logic [3:0]    row_next;

    scan_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchronizer for the asynchronous column returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_meta <= '0;
            col_s    <= '0;
        end else begin
            col_meta <= col;
            col_s    <= col_meta;
        end
    end

    assign row_idx  = onehot_to_idx(row);
    assign col_idx  = onehot_to_idx(col_s);
    assign col_ok   = is_onehot(col_s);
    assign row_next = {row[2:0], row[3]};

    // The sequencer advances only on a dwell tick.
    // match_cnt includes the tick on which the key was first detected.
    // The press is accepted when match_cnt reaches DEBOUNCE_CNT.
    // A key in the debounce window is "the same key" when col_s is one-hot
    // and has the same column index as the candidate. The row is frozen
    // during debounce, so this matches the row too.
    // key_valid is cleared on every cycle unless an accept happens that cycle,
    // so it is high for exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_SCAN;
            row       <= 4'b0001;
            key       <= KEY_NONE;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            cand      <= '0;
            match_cnt <= '0;
            rel_cnt   <= '0;
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    S_SCAN: begin
                        if (col_ok) begin
                            cand      <= {row_idx, col_idx};
                            match_cnt <= MW'(1);
                            if (DEBOUNCE_CNT == 1) begin
                                state     <= S_PRESSED;
                                key       <= {1'b0, row_idx, col_idx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                match_cnt <= '0;
                                rel_cnt   <= '0;
                            end else begin
                                state <= S_DEBOUNCE;
                            end
                        end else begin
                            row <= row_next;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (col_ok && (col_idx == cand[1:0])) begin
                            if (match_cnt == MATCH_LAST) begin
                                state     <= S_PRESSED;
                                key       <= {1'b0, cand};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                match_cnt <= '0;
                                rel_cnt   <= '0;
                            end else begin
                                match_cnt <= match_cnt + MW'(1);
                            end
                        end else begin
                            state     <= S_SCAN;
                            row       <= row_next;
                            match_cnt <= '0;
                        end
                    end
                    S_PRESSED: begin
                        if (col_s == 4'd0) begin
                            if (rel_cnt == MATCH_LAST) begin
                                state    <= S_SCAN;
                                key_held <= 1'b0;
                                row      <= row_next;
                                rel_cnt  <= '0;
                            end else begin
                                rel_cnt <= rel_cnt + MW'(1);
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                    default: begin
                        state <= S_SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// ============================================================================
// tb_keypad_scan_ctrl
// Testbench for keypad_scan_ctrl with SCAN_DIV=4 and DEBOUNCE_CNT=3.
// The keypad is modelled as a 16-bit mask of pressed keys. Bit r*4+c set means
// the key at row r, column c is down. The column returns are the mask nibble
// of whichever row the DUT is strobing.
// A tick-level reference model predicts row, key, key_valid and key_held on
// every cycle.
// ============================================================================
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col;
    logic [3:0] row;
    logic [4:0] key;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pad_mask = 16'd0;

    int tests_run    = 0;
    int tests_failed = 0;

    int m_k, m_row, m_key, m_streak, m_cand, m_rel;
    bit m_valid, m_held;
    int dut_pulses = 0;
    int mdl_pulses = 0;

    keypad_scan_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // The physical keypad: a strobed row shorts its pressed keys onto the columns.
    always_comb begin
        col = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (row[r]) col = col | pad_mask[r*4 +: 4];
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int colIndex(input int c);
        if (c == 1) return 0;
        if (c == 2) return 1;
        if (c == 4) return 2;
        return 3;
    endfunction

    // Reference behaviour for one rising edge.
    // The keypad mask changes only at the start of a dwell, so at a tick the
    // synchronized columns equal the mask nibble of the row being scanned.
    task automatic modelEdge(input bit rst);
        int c;
        if (rst) begin
            m_k = 0; m_row = 0; m_key = 16; m_valid = 0; m_held = 0;
            m_streak = 0; m_rel = 0; m_cand = 0;
            return;
        end
        m_valid = 0;
        if ((m_k % SCAN_DIV) == SCAN_DIV - 1) begin
            c = int'((pad_mask >> (m_row * 4)) & 16'hF);
            if (m_held) begin
                if (c == 0) m_rel++;
                else m_rel = 0;
                if (m_rel == DEB) begin
                    m_held = 0;
                    m_rel  = 0;
                    m_row  = (m_row + 1) % 4;
                end
            end else begin
                if (m_streak == 0) begin
                    if ($countones(c) == 1) begin
                        m_streak = 1;
                        m_cand   = c;
                    end else begin
                        m_row = (m_row + 1) % 4;
                    end
                end else if (c == m_cand) begin
                    m_streak++;
                end else begin
                    m_streak = 0;
                    m_row    = (m_row + 1) % 4;
                end
                if (m_streak == DEB) begin
                    m_key    = m_row * 4 + colIndex(m_cand);
                    m_held   = 1;
                    m_valid  = 1;
                    m_streak = 0;
                    m_rel    = 0;
                    mdl_pulses++;
                end
            end
        end
        m_k++;
    endtask

    // Drive one cycle of stimulus from a falling edge.
    // The expected outputs are then compared on the following falling edge.
    task automatic applyStimulus(input bit rst, input logic [15:0] msk);
        reset    = rst;
        pad_mask = msk;
        modelEdge(rst);
        @(posedge clk);
        @(negedge clk);
        if (key_valid === 1'b1) dut_pulses++;
        checkOutput("row", 16'(row), 16'd1 << m_row);
        checkOutput("key", 16'(key), 16'(m_key));
        checkOutput("key_valid", 16'(key_valid), 16'(m_valid));
        checkOutput("key_held", 16'(key_held), 16'(m_held));
    endtask

    task automatic runTicks(input logic [15:0] msk, input int n);
        repeat (n * SCAN_DIV) applyStimulus(1'b0, msk);
    endtask

    task automatic doReset(input int offset, input int hold);
        repeat (offset) applyStimulus(1'b0, pad_mask);
        repeat (hold) applyStimulus(1'b1, pad_mask);
        checkOutput("rst_row", 16'(row), 16'h1);
        checkOutput("rst_key", 16'(key), 16'h10);
        checkOutput("rst_held", 16'(key_held), 16'h0);
        checkOutput("rst_valid", 16'(key_valid), 16'h0);
    endtask

    localparam logic [15:0] K06 = 16'h0040;
    localparam logic [15:0] K0F = 16'h8000;

    initial begin
        int p0;
        int sel;
        logic [15:0] m;
        @(negedge clk);

        // Reset held for 3 cycles, then 10 idle dwells of row rotation.
        doReset(0, 3);
        runTicks(16'd0, 10);

        // Single press of key 06, held long enough to be accepted.
        p0 = dut_pulses;
        runTicks(K06, 12);
        checkOutput("s2_pulses", 16'(dut_pulses - p0), 16'd1);
        checkOutput("s2_key", 16'(key), 16'h06);
        checkOutput("s2_held", 16'(key_held), 16'h1);
        checkOutput("s2_row", 16'(row), 16'b0010);

        // Release the key, then press it again.
        runTicks(16'd0, 6);
        checkOutput("s3_held", 16'(key_held), 16'h0);
        checkOutput("s3_key", 16'(key), 16'h06);
        p0 = dut_pulses;
        runTicks(K06, 12);
        checkOutput("s3_repress", 16'(dut_pulses - p0), 16'd1);
        runTicks(16'd0, 6);

        // Bouncing contact, then a stable press.
        p0 = dut_pulses;
        for (int i = 0; i < 5; i++) runTicks((i % 2 == 0) ? K06 : 16'd0, 1);
        checkOutput("s4_bounce", 16'(dut_pulses - p0), 16'd0);
        runTicks(K06, 12);
        checkOutput("s4_key", 16'(key), 16'h06);
        runTicks(16'd0, 6);

        // Multi-hot on row 3 is ignored. Key 0F is accepted, and a rollover key is ignored.
        p0 = dut_pulses;
        runTicks(16'h5000, 10);
        checkOutput("s5_multihot", 16'(dut_pulses - p0), 16'd0);
        runTicks(K0F, 12);
        checkOutput("s5_key", 16'(key), 16'h0F);
        p0 = dut_pulses;
        runTicks(K0F | 16'h0001, 10);
        checkOutput("s5_rollover", 16'(dut_pulses - p0), 16'd0);
        checkOutput("s5_key2", 16'(key), 16'h0F);
        runTicks(16'd0, 6);

        // Reset while debouncing, then reset while pressed.
        for (int i = 0; i < 20 && m_streak == 0; i++) runTicks(K06, 1);
        checkOutput("s6_in_debounce", 16'(m_streak > 0), 16'd1);
        doReset($urandom_range(0, 2), 1);
        for (int i = 0; i < 20 && !m_held; i++) runTicks(K06, 1);
        checkOutput("s6_in_pressed", 16'(m_held), 16'd1);
        doReset($urandom_range(0, 2), 2);
        runTicks(16'd0, 2);

        // Random presses, releases and resets.
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                doReset($urandom_range(0, 2), $urandom_range(1, 3));
            end else begin
                if (sel < 4) m = 16'd0;
                else if (sel < 8) m = 16'd1 << $urandom_range(0, 15);
                else m = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
                runTicks(m, $urandom_range(1, 8));
            end
        end

        checkOutput("pulse_total", 16'(dut_pulses), 16'(mdl_pulses));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
